// File: rtl/sseg_scan_ctrl_if.sv
// Write port bundle for sseg_scan_ctrl.
//   wr_en   : write strobe, one write per cycle
//   wr_addr : digit index (0 = rightmost, 3 = leftmost)
//   wr_data : 4-bit hex value for that digit
// master drives the bundle, slave (the scan controller) receives it.
interface sseg_scan_ctrl_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [3:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/sseg_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit common-ground
// seven-segment display.
//
// Parameters:
//   REFRESH_DIV  : cycles each digit is lit (>=1)
//   BLANK_CYCLES : dark cycles between digits (>=1)
// Ports:
//   clk        : rising-edge clock
//   rst_n      : synchronous active-low reset
//   wr         : write port (sseg_scan_ctrl_if.slave: wr_en/wr_addr/wr_data)
//   digit_en   : per-digit enable mask; disabled digit keeps its slot dark
//   grounds    : active-low digit grounds, bit i = digit i (registered)
//   display    : active-high segments, bit6 = a .. bit0 = g (registered)
//   frame_tick : one-cycle pulse in the last blank cycle after digit 3
// Build option:
//   SSEG_LZ_BLANK_EN : leading-zero suppression for digits 1..3
module sseg_scan_ctrl #(
  parameter int REFRESH_DIV  = 50000,
  parameter int BLANK_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst_n,
  sseg_scan_ctrl_if.slave         wr,
  input  logic [3:0]              digit_en,
  output logic [3:0]              grounds,
  output logic [6:0]              display,
  output logic                    frame_tick
);

  localparam int MAXC = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] SHOW_LAST  = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, nstate;
  logic [1:0]      idx, nidx;
  logic [CW-1:0]   cnt, ncnt;
  logic            first, nfirst;
  logic [3:0]      val   [4];
  logic [3:0]      vnext [4];
  logic            show_on;
  logic [3:0]      ngr;
  logic [6:0]      nds;
  logic            ntick;

  function automatic logic [6:0] seg(input logic [3:0] h);
    logic [6:0] s;
    case (h)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  // Write data is forwarded into the output decode so a write to the
  // digit being shown is visible the cycle right after the write edge.
  always_comb begin
    for (int unsigned i = 0; i < 4; i++) begin
      vnext[i] = (wr.wr_en && (wr.wr_addr == 2'(i))) ? wr.wr_data : val[i];
    end
  end

  always_comb begin
    nstate = state;
    nidx   = idx;
    nfirst = first;
    ncnt   = cnt + CW'(1);
    case (state)
      BLANK: if (cnt == BLANK_LAST) begin
        nstate = SHOW;
        ncnt   = '0;
        nfirst = 1'b0;
        // the blank phase right after reset starts the scan at digit 0
        nidx   = first ? 2'd0 : idx + 2'd1;
      end
      default: if (cnt == SHOW_LAST) begin
        nstate = BLANK;
        ncnt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered pins always
  // match the state/idx they are registered alongside.
  always_comb begin
    show_on = digit_en[nidx];
`ifdef SSEG_LZ_BLANK_EN
    if (nidx != 2'd0) begin
      logic all_zero;
      all_zero = 1'b1;
      for (int unsigned k = 0; k < 4; k++) begin
        if ((2'(k) >= nidx) && (vnext[k] != 4'h0)) all_zero = 1'b0;
      end
      if (all_zero) show_on = 1'b0;
    end
`endif
    ngr = '1;
    nds = '0;
    if ((nstate == SHOW) && show_on) begin
      ngr[nidx] = 1'b0;
      nds       = seg(vnext[nidx]);
    end
    ntick = (nstate == BLANK) && (ncnt == BLANK_LAST) && (nidx == 2'd3) && !nfirst;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= BLANK;
      idx        <= 2'd0;
      cnt        <= '0;
      first      <= 1'b1;
      for (int unsigned i = 0; i < 4; i++) val[i] <= '0;
      grounds    <= '1;
      display    <= '0;
      frame_tick <= 1'b0;
    end else begin
      state      <= nstate;
      idx        <= nidx;
      cnt        <= ncnt;
      first      <= nfirst;
      for (int unsigned i = 0; i < 4; i++) val[i] <= vnext[i];
      grounds    <= ngr;
      display    <= nds;
      frame_tick <= ntick;
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
module tb_sseg_scan_ctrl;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] en = 4'b1111;
  logic [3:0] grounds;
  logic [6:0] display;
  logic       frame_tick;
  int         total = 0;
  int         bad = 0;
  int         t = 0;
  logic [3:0] mval [4] = '{4'h0, 4'h0, 4'h0, 4'h0};
  logic [6:0] segtab [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111};

  sseg_scan_ctrl_if wr ();

  sseg_scan_ctrl #(.REFRESH_DIV(8), .BLANK_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n), .wr(wr.slave), .digit_en(en),
    .grounds(grounds), .display(display), .frame_tick(frame_tick));

  always #5 clk = ~clk;

  // cycle index since the first blank cycle after reset
  always @(posedge clk) begin
    if (!rst_n) t <= 0;
    else        t <= t + 1;
  end

  // Expected pins for cycle t: 2 dark cycles, then slots of 8 lit + 2 dark
  // per digit, frame period 40.
  function automatic void model(output logic [3:0] g, output logic [6:0] s, output logic tk);
    int u, d, r;
    logic on;
    g = 4'b1111; s = 7'b0; tk = 1'b0;
    if (t >= 2) begin
      u = (t - 2) % 40; d = u / 10; r = u % 10;
      if (r < 8) begin
        on = en[d];
`ifdef SSEG_LZ_BLANK_EN
        if (d > 0) begin
          logic lz;
          lz = 1'b1;
          for (int k = d; k < 4; k++) if (mval[k] != 4'h0) lz = 1'b0;
          if (lz) on = 1'b0;
        end
`endif
        if (on) begin g[d] = 1'b0; s = segtab[mval[d]]; end
      end else if (d == 3 && r == 9) begin
        tk = 1'b1;
      end
    end
  endfunction

  function automatic int pos();
    return (t >= 2) ? (t - 2) % 40 : -1;
  endfunction

  task automatic test_reset();
    logic [3:0] eg; logic [6:0] es; logic et;
    rst_n = 1'b0; wr.wr_en = 1'b0; wr.wr_addr = 2'd0; wr.wr_data = 4'h0; en = 4'b1111;
    repeat (3) @(negedge clk);
    total++;
    if ({grounds, display, frame_tick} !== {4'b1111, 7'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_hold got g=%b d=%b tk=%b want g=1111 d=0000000 tk=0", grounds, display, frame_tick);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      model(eg, es, et);
      total++;
      if ({grounds, display, frame_tick} !== {eg, es, et}) begin
        bad++;
        $display("FAIL reset_release t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
      end
    end
  endtask

  task automatic test_full_scan();
    logic [3:0] eg; logic [6:0] es; logic et;
    logic [3:0] v [4];
    int ticks = 0;
    v = '{4'h1, 4'h5, 4'hA, 4'hF};
    // back-to-back writes, one per cycle, checked while scanning
    for (int c = 0; c < 84; c++) begin
      if (c < 4) begin
        wr.wr_en = 1'b1; wr.wr_addr = 2'(c); wr.wr_data = v[c]; mval[c] = v[c];
      end else begin
        wr.wr_en = 1'b0;
      end
      @(negedge clk);
      model(eg, es, et);
      if (frame_tick === 1'b1) ticks++;
      total++;
      if ({grounds, display, frame_tick} !== {eg, es, et}) begin
        bad++;
        $display("FAIL full_scan t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
      end
    end
    total++;
    if (ticks != 2) begin
      bad++;
      $display("FAIL full_scan_ticks got %0d want 2", ticks);
    end
  endtask

  task automatic test_live_write();
    logic [3:0] eg; logic [6:0] es; logic et;
    int found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (pos() == 3) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL live_write_wait got no digit0 slot want one within 100 cycles");
    end else begin
      wr.wr_en = 1'b1; wr.wr_addr = 2'd0; wr.wr_data = 4'h8; mval[0] = 4'h8;
      @(negedge clk);
      wr.wr_en = 1'b0;
      total++;
      if ({grounds, display} !== {4'b1110, 7'b1111111}) begin
        bad++;
        $display("FAIL live_write_next got g=%b d=%b want g=1110 d=1111111", grounds, display);
      end
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        model(eg, es, et);
        total++;
        if ({grounds, display, frame_tick} !== {eg, es, et}) begin
          bad++;
          $display("FAIL live_write_slot t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
        end
      end
    end
  endtask

  task automatic test_mask();
    logic [3:0] eg; logic [6:0] es; logic et;
    int last_tick = -1;
    en = 4'b0101;
    for (int c = 0; c < 90; c++) begin
      @(negedge clk);
      model(eg, es, et);
      total++;
      if ({grounds, display, frame_tick} !== {eg, es, et}) begin
        bad++;
        $display("FAIL mask t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
      end
      if (frame_tick === 1'b1) begin
        if (last_tick >= 0) begin
          total++;
          if (t - last_tick != 40) begin
            bad++;
            $display("FAIL mask_period got %0d want 40", t - last_tick);
          end
        end
        last_tick = t;
      end
    end
    en = 4'b1111;
  endtask

  task automatic test_mid_reset();
    logic [3:0] eg; logic [6:0] es; logic et;
    int found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clk);
      if (pos() == 23) found = 1;
    end
    total++;
    if (found == 0) begin
      bad++;
      $display("FAIL mid_reset_wait got no digit2 slot want one within 100 cycles");
    end else begin
      rst_n = 1'b0;
      for (int i = 0; i < 4; i++) mval[i] = 4'h0;
      @(negedge clk);
      total++;
      if ({grounds, display, frame_tick} !== {4'b1111, 7'b0, 1'b0}) begin
        bad++;
        $display("FAIL mid_reset_dark got g=%b d=%b tk=%b want g=1111 d=0000000 tk=0", grounds, display, frame_tick);
      end
      rst_n = 1'b1;
      for (int c = 0; c < 45; c++) begin
        @(negedge clk);
        model(eg, es, et);
        total++;
        if ({grounds, display, frame_tick} !== {eg, es, et}) begin
          bad++;
          $display("FAIL mid_reset_restart t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
        end
      end
    end
  endtask

  task automatic test_leading_zero();
    logic [3:0] eg; logic [6:0] es; logic et;
    logic [3:0] v [4];
    v = '{4'h0, 4'h0, 4'h3, 4'h0};
    for (int c = 0; c < 45; c++) begin
      if (c < 4) begin
        wr.wr_en = 1'b1; wr.wr_addr = 2'(c); wr.wr_data = v[c]; mval[c] = v[c];
      end else begin
        wr.wr_en = 1'b0;
      end
      @(negedge clk);
      model(eg, es, et);
      total++;
      if ({grounds, display, frame_tick} !== {eg, es, et}) begin
        bad++;
        $display("FAIL leading_zero t=%0d got g=%b d=%b tk=%b want g=%b d=%b tk=%b", t, grounds, display, frame_tick, eg, es, et);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_scan();
    test_live_write();
    test_mask();
    test_mid_reset();
    test_leading_zero();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
